// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU.
// Resolves source operands by forwarding from EX/MEM and inserts a bubble on a load-use hazard.
module id_ex_operand_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RA_W   = 5,
   parameter int unsigned FUNC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              flush_in,
   input  logic              id_valid,
   input  logic [RA_W-1:0]   id_rs,
   input  logic [RA_W-1:0]   id_rt,
   input  logic [RA_W-1:0]   id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_use_imm,
   input  logic [FUNC_W-1:0] id_func,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [RA_W-1:0]   mem_rd,
   input  logic              mem_reg_write,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] in1,
   output logic [DATA_W-1:0] in2,
   output logic [FUNC_W-1:0] func,
   output logic [RA_W-1:0]   ex_rd,
   output logic [DATA_W-1:0] ex_store_data,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              load_use_stall
);

   localparam logic [RA_W-1:0] ZERO_RA = '0;

   logic              ex_fwd_ok;
   logic              bubble;
   logic [DATA_W-1:0] rs_fwd;
   logic [DATA_W-1:0] rt_fwd;

   // A load in EX has no data yet, so it can only be forwarded from MEM
   always_comb begin
      ex_fwd_ok = ex_valid & ex_reg_write & ~ex_mem_read;

      rs_fwd = id_rs_data;
      if (id_rs == ZERO_RA)                       rs_fwd = '0;
      else if (ex_fwd_ok && (ex_rd == id_rs))     rs_fwd = alu_result;
      else if (mem_reg_write && (mem_rd == id_rs)) rs_fwd = mem_data;

      rt_fwd = id_rt_data;
      if (id_rt == ZERO_RA)                       rt_fwd = '0;
      else if (ex_fwd_ok && (ex_rd == id_rt))     rt_fwd = alu_result;
      else if (mem_reg_write && (mem_rd == id_rt)) rt_fwd = mem_data;

      load_use_stall = ex_valid & ex_mem_read & id_valid & (ex_rd != ZERO_RA) &
                       ((ex_rd == id_rs) |
                        ((ex_rd == id_rt) & (~id_use_imm | id_mem_write)));

      bubble = load_use_stall | ~id_valid;
   end

   // Priority: reset, flush, stall hold, hazard/empty-slot bubble, capture
   always_ff @(posedge clk) begin
      if (rst || flush_in || (!stall_in && bubble)) begin
         in1           <= '0;
         in2           <= '0;
         func          <= '0;
         ex_rd         <= '0;
         ex_store_data <= '0;
         ex_valid      <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
      end else if (!stall_in) begin
         in1           <= rs_fwd;
         in2           <= id_use_imm ? id_imm : rt_fwd;
         func          <= id_func;
         ex_rd         <= id_rd;
         ex_store_data <= rt_fwd;
         ex_valid      <= 1'b1;
         ex_reg_write  <= id_reg_write;
         ex_mem_read   <= id_mem_read;
         ex_mem_write  <= id_mem_write;
      end
   end

endmodule
